// File: rtl/cpu_pkg.sv
// Shared fetch-stage definitions: state encoding, instruction width and
// the branch/jump offset field positions within an instruction word.
package cpu_pkg;

    localparam int INSTR_W     = 16;
    localparam int BR_OFF_MSB  = 7;
    localparam int JMP_OFF_MSB = 10;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        FS_LOAD = 2'b00,
        FS_RUN  = 2'b01,
        FS_HALT = 2'b10
    } fetch_state_t;

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC priority mux: halt hold, branch, label jump, Rm, Rd, sequential.
// All arithmetic is done at instruction width and truncated to the PC width.
module next_pc_sel
    import cpu_pkg::*;
#(
    parameter int PW = 8
) (
    input  logic [PW-1:0]      pc,
    input  logic [INSTR_W-1:0] instr,
    input  logic               branch,
    input  logic               flag_label_pc,
    input  logic               flag_rm_pc,
    input  logic               flag_rd_pc,
    input  logic               flag_hlt,
    input  logic [INSTR_W-1:0] rm_data,
    input  logic [INSTR_W-1:0] rd_data,
    output logic [PW-1:0]      next_pc,
    output logic [PW-1:0]      pc_plus1
);

    logic [INSTR_W-1:0] pc_ext;
    logic [INSTR_W-1:0] seq_pc;
    logic [INSTR_W-1:0] br_off;
    logic [INSTR_W-1:0] jmp_off;
    logic [INSTR_W-1:0] sel;
    logic               unused_bits;

    always_comb begin
        pc_ext  = INSTR_W'(pc);
        seq_pc  = pc_ext + INSTR_W'(1);
        br_off  = {{(INSTR_W-1-BR_OFF_MSB){instr[BR_OFF_MSB]}}, instr[BR_OFF_MSB:0]};
        jmp_off = {{(INSTR_W-1-JMP_OFF_MSB){instr[JMP_OFF_MSB]}}, instr[JMP_OFF_MSB:0]};
        if (flag_hlt)
            sel = pc_ext;
        else if (branch)
            sel = seq_pc + br_off;
        else if (flag_label_pc)
            sel = seq_pc + jmp_off;
        else if (flag_rm_pc)
            sel = rm_data;
        else if (flag_rd_pc)
            sel = rd_data;
        else
            sel = seq_pc;
    end

    // Upper bits wrap away silently: the PC is modulo the memory depth.
    assign next_pc     = sel[PW-1:0];
    assign pc_plus1    = seq_pc[PW-1:0];
    assign unused_bits = ^{sel, seq_pc, instr[INSTR_W-1:JMP_OFF_MSB+1]};

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch: program load port, instruction memory, PC and run/halt FSM.
// Define FETCH_PERF_EN to add the instr_count / taken_count performance counters.
//
// state   | meaning
// FS_LOAD | streaming program words into imem, load_ready high
// FS_RUN  | presenting imem[PC] each cycle, core enabled
// FS_HALT | stopped after flag_HLT, waiting for rerun or a new program
module instruction_fetch
    import cpu_pkg::*;
#(
    parameter int  DEPTH    = 256,
    parameter int  RESET_PC = 0,
    localparam int PW       = $clog2(DEPTH)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               load_last,
    output logic               load_ready,
    input  logic               rerun,
    input  logic               BRANCH,
    input  logic               flag_label_PC,
    input  logic               flag_Rm_PC,
    input  logic               flag_Rd_PC,
    input  logic               flag_HLT,
    input  logic [INSTR_W-1:0] Rm_data,
    input  logic [INSTR_W-1:0] Rd_data,
    output logic [INSTR_W-1:0] Instruction,
    output logic [PW-1:0]      PC,
    output logic [PW-1:0]      PC_plus1,
    output logic               core_en,
    output logic [1:0]         state
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        instr_count,
    output logic [15:0]        taken_count
`endif
);

    fetch_state_t       state_q, state_d;
    logic [PW-1:0]      pc_d, wr_ptr, wr_ptr_d, next_pc, mem_addr;
    logic               mem_we;
    logic [INSTR_W-1:0] imem [DEPTH];

    next_pc_sel #(.PW(PW)) u_next_pc_sel (
        .pc            (PC),
        .instr         (Instruction),
        .branch        (BRANCH),
        .flag_label_pc (flag_label_PC),
        .flag_rm_pc    (flag_Rm_PC),
        .flag_rd_pc    (flag_Rd_PC),
        .flag_hlt      (flag_HLT),
        .rm_data       (Rm_data),
        .rd_data       (Rd_data),
        .next_pc       (next_pc),
        .pc_plus1      (PC_plus1)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= FS_LOAD;
            PC      <= PW'(RESET_PC);
            wr_ptr  <= '0;
        end else begin
            state_q <= state_d;
            PC      <= pc_d;
            wr_ptr  <= wr_ptr_d;
        end
    end

    // Memory is deliberately not reset; a reload simply overwrites it.
    always_ff @(posedge CLK) begin
        if (mem_we && !RST)
            imem[mem_addr] <= load_data;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = PC;
        wr_ptr_d = wr_ptr;
        mem_we   = 1'b0;
        mem_addr = wr_ptr;
        case (state_q)
            FS_LOAD: begin
                if (load_valid) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr + PW'(1);
                    if (load_last || wr_ptr == PW'(DEPTH - 1)) begin
                        state_d  = FS_RUN;
                        pc_d     = PW'(RESET_PC);
                        wr_ptr_d = '0;
                    end
                end
            end
            FS_RUN: begin
                pc_d = next_pc;
                if (flag_HLT)
                    state_d = FS_HALT;
            end
            FS_HALT: begin
                if (load_valid) begin
                    mem_we   = 1'b1;
                    mem_addr = '0;
                    if (load_last) begin
                        state_d  = FS_RUN;
                        pc_d     = PW'(RESET_PC);
                        wr_ptr_d = '0;
                    end else begin
                        state_d  = FS_LOAD;
                        wr_ptr_d = PW'(1);
                    end
                end else if (rerun) begin
                    state_d = FS_RUN;
                    pc_d    = PW'(RESET_PC);
                end
            end
            default: begin
                state_d  = FS_LOAD;
                pc_d     = PW'(RESET_PC);
                wr_ptr_d = '0;
            end
        endcase
    end

    always_comb begin
        core_en     = (state_q == FS_RUN);
        load_ready  = (state_q != FS_RUN);
        Instruction = (state_q == FS_RUN) ? imem[PC] : NOP_INSTR;
        state       = state_q;
    end

`ifdef FETCH_PERF_EN
    logic perf_clear, taken;

    // Any entry into RUN that came with a fresh program restarts the counts.
    assign perf_clear = (state_d == FS_RUN) &&
                        ((state_q == FS_LOAD) || (state_q == FS_HALT && load_valid));
    assign taken = (BRANCH || flag_label_PC || flag_Rm_PC || flag_Rd_PC) && !flag_HLT;

    always_ff @(posedge CLK) begin
        if (RST || perf_clear) begin
            instr_count <= '0;
            taken_count <= '0;
        end else if (state_q == FS_RUN) begin
            if (instr_count != 16'hFFFF)
                instr_count <= instr_count + 16'd1;
            if (taken && taken_count != 16'hFFFF)
                taken_count <= taken_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: load/run/halt sequences plus a
// table of next-PC selection vectors against a bench-side memory image.
module tb_instruction_fetch;

    localparam int DEPTH = 256;

    logic        CLK = 1'b0;
    logic        RST;
    logic        load_valid, load_last, load_ready, rerun;
    logic        BRANCH, flag_label_PC, flag_Rm_PC, flag_Rd_PC, flag_HLT;
    logic [15:0] load_data, Rm_data, Rd_data, Instruction;
    logic [7:0]  PC, PC_plus1;
    logic        core_en;
    logic [1:0]  state;
`ifdef FETCH_PERF_EN
    logic [15:0] instr_count, taken_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem_m [DEPTH];

    typedef struct {
        logic [7:0]  start;
        logic        br, lab, rm, rd;
        logic [15:0] rmd, rdd;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs [12];

    instruction_fetch #(.DEPTH(DEPTH), .RESET_PC(0)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .load_valid    (load_valid),
        .load_data     (load_data),
        .load_last     (load_last),
        .load_ready    (load_ready),
        .rerun         (rerun),
        .BRANCH        (BRANCH),
        .flag_label_PC (flag_label_PC),
        .flag_Rm_PC    (flag_Rm_PC),
        .flag_Rd_PC    (flag_Rd_PC),
        .flag_HLT      (flag_HLT),
        .Rm_data       (Rm_data),
        .Rd_data       (Rd_data),
        .Instruction   (Instruction),
        .PC            (PC),
        .PC_plus1      (PC_plus1),
        .core_en       (core_en),
        .state         (state)
`ifdef FETCH_PERF_EN
        ,
        .instr_count   (instr_count),
        .taken_count   (taken_count)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_in();
        load_valid    = 1'b0;
        load_last     = 1'b0;
        load_data     = 16'h0000;
        rerun         = 1'b0;
        BRANCH        = 1'b0;
        flag_label_PC = 1'b0;
        flag_Rm_PC    = 1'b0;
        flag_Rd_PC    = 1'b0;
        flag_HLT      = 1'b0;
        Rm_data       = 16'h0000;
        Rd_data       = 16'h0000;
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [15:0] words [3];
        words[0] = 16'h0800;
        words[1] = 16'h1000;
        words[2] = 16'hE001;

        for (int i = 0; i < DEPTH; i++) mem_m[i] = {8'h5A, 8'(i)};
        mem_m[3]   = 16'h0400;
        mem_m[5]   = 16'hC0FE;
        mem_m[6]   = 16'h87FF;
        mem_m[10]  = 16'h007F;
        mem_m[250] = 16'h0010;

        vecs[0]  = '{8'd5,   1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'd4};
        vecs[1]  = '{8'd6,   1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'd6};
        vecs[2]  = '{8'd5,   1'b0, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 8'h34};
        vecs[3]  = '{8'd5,   1'b1, 1'b0, 1'b1, 1'b0, 16'h1234, 16'h0000, 8'd4};
        vecs[4]  = '{8'd255, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'd0};
        vecs[5]  = '{8'd10,  1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 16'hABCD, 8'hCD};
        vecs[6]  = '{8'd10,  1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'd138};
        vecs[7]  = '{8'd250, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'd11};
        vecs[8]  = '{8'd3,   1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'd4};
        vecs[9]  = '{8'd6,   1'b0, 1'b1, 1'b1, 1'b1, 16'h0055, 16'h0066, 8'd6};
        vecs[10] = '{8'd5,   1'b0, 1'b0, 1'b1, 1'b1, 16'h0077, 16'h0099, 8'h77};
        vecs[11] = '{8'd0,   1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 8'd1};

        clear_in();
        RST = 1'b1;
        tick();
        tick();
        check("rst_state", 16'(state), 16'h0000);
        check("rst_pc", 16'(PC), 16'h0000);
        check("rst_load_ready", 16'(load_ready), 16'h0001);
        check("rst_core_en", 16'(core_en), 16'h0000);
        check("rst_instr", Instruction, 16'h0000);
        RST = 1'b0;

        for (int i = 0; i < 3; i++) begin
            load_valid = 1'b1;
            load_data  = words[i];
            load_last  = (i == 2);
            check("load3_ready", 16'(load_ready), 16'h0001);
            tick();
            if (i < 2) check("load3_state", 16'(state), 16'h0000);
        end
        clear_in();
        check("load3_run_state", 16'(state), 16'h0001);
        check("load3_pc", 16'(PC), 16'h0000);
        check("load3_instr", Instruction, 16'h0800);
        check("load3_core_en", 16'(core_en), 16'h0001);
        check("run_load_ready", 16'(load_ready), 16'h0000);

        tick();
        check("seq_pc1", 16'(PC), 16'h0001);
        check("seq_instr1", Instruction, 16'h1000);
        tick();
        check("seq_pc2", 16'(PC), 16'h0002);
        check("seq_pc_plus1", 16'(PC_plus1), 16'h0003);
        check("seq_instr2", Instruction, 16'hE001);

        flag_HLT = 1'b1;
        tick();
        clear_in();
        check("hlt_state", 16'(state), 16'h0002);
        check("hlt_pc", 16'(PC), 16'h0002);
        check("hlt_instr", Instruction, 16'h0000);
        check("hlt_core_en", 16'(core_en), 16'h0000);
        check("hlt_load_ready", 16'(load_ready), 16'h0001);

        BRANCH     = 1'b1;
        flag_Rm_PC = 1'b1;
        Rm_data    = 16'h0040;
        tick();
        clear_in();
        check("hlt_flags_ignored_pc", 16'(PC), 16'h0002);
        check("hlt_flags_ignored_state", 16'(state), 16'h0002);

        // Full-depth reload started from HALT, no load_last anywhere.
        for (int i = 0; i < DEPTH; i++) begin
            load_valid = 1'b1;
            load_data  = mem_m[i];
            tick();
            if (i == 0)   check("halt_to_load", 16'(state), 16'h0000);
            if (i == 254) check("full_not_yet", 16'(state), 16'h0000);
        end
        clear_in();
        check("full_auto_run", 16'(state), 16'h0001);
        check("full_pc", 16'(PC), 16'h0000);
        check("full_instr0", Instruction, mem_m[0]);

        for (int v = 0; v < 12; v++) begin
            flag_Rm_PC = 1'b1;
            Rm_data    = {8'h00, vecs[v].start};
            tick();
            clear_in();
            check("vec_setup_pc", 16'(PC), 16'(vecs[v].start));
            check("vec_instr", Instruction, mem_m[vecs[v].start]);
            check("vec_pc_plus1", 16'(PC_plus1), 16'(8'(vecs[v].start + 8'd1)));
            BRANCH        = vecs[v].br;
            flag_label_PC = vecs[v].lab;
            flag_Rm_PC    = vecs[v].rm;
            flag_Rd_PC    = vecs[v].rd;
            Rm_data       = vecs[v].rmd;
            Rd_data       = vecs[v].rdd;
            tick();
            clear_in();
            check($sformatf("vec%0d_next_pc", v), 16'(PC), 16'(vecs[v].exp));
        end

        rerun = 1'b1;
        tick();
        clear_in();
        check("rerun_ignored_in_run", 16'(PC), 16'h0002);

        flag_HLT = 1'b1;
        tick();
        clear_in();
        check("hlt2_state", 16'(state), 16'h0002);
        check("hlt2_pc", 16'(PC), 16'h0002);

        rerun = 1'b1;
        tick();
        clear_in();
        check("rerun_state", 16'(state), 16'h0001);
        check("rerun_pc", 16'(PC), 16'h0000);
        check("rerun_instr", Instruction, mem_m[0]);

        flag_HLT = 1'b1;
        tick();
        clear_in();
        rerun      = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'h1111;
        tick();
        clear_in();
        check("load_beats_rerun", 16'(state), 16'h0000);
        load_valid = 1'b1;
        load_data  = 16'h2222;
        load_last  = 1'b1;
        tick();
        clear_in();
        mem_m[0] = 16'h1111;
        mem_m[1] = 16'h2222;
        check("reload_state", 16'(state), 16'h0001);
        check("reload_pc", 16'(PC), 16'h0000);
        check("reload_instr0", Instruction, mem_m[0]);
        tick();
        check("reload_instr1", Instruction, mem_m[1]);

        flag_HLT = 1'b1;
        tick();
        clear_in();
        load_valid = 1'b1;
        load_data  = 16'h3333;
        load_last  = 1'b1;
        tick();
        clear_in();
        check("halt_load_last_state", 16'(state), 16'h0001);
        check("halt_load_last_instr", Instruction, 16'h3333);

        tick();
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("midrun_rst_state", 16'(state), 16'h0000);
        check("midrun_rst_pc", 16'(PC), 16'h0000);
        check("midrun_rst_instr", Instruction, 16'h0000);
        check("midrun_rst_core_en", 16'(core_en), 16'h0000);

        load_valid = 1'b1;
        load_data  = 16'h4444;
        load_last  = 1'b1;
        tick();
        clear_in();
        check("post_rst_load_instr", Instruction, 16'h4444);
        check("post_rst_load_state", 16'(state), 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
